sh_ibus_ram: RTL and testbench

Parametrised on-chip RAM slave for the SH internal bus (IBUS). It is the next generation of the fixed 4 KB CPU RAM. Depth, address window and read wait states are configurable, and it adds a post-reset clear engine that drives IBUS_BUSY. It also has true per-byte-lane write enables and defined read-during-write behaviour. It sits on IBUS beside the other on-chip slaves, and the bus master's IBUS_ACT mux selects its IBUS_DO.

---
 rtl/sh_ibus_ram.sv | 146 ++++++++++++++
 tb/tb_sh_ibus_ram.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sh_ibus_ram.sv
// sh_ibus_ram: on-chip RAM slave for the SH internal bus with configurable depth,
// address window and read wait states, plus an optional post-reset clear engine.
module sh_ibus_ram #(
    parameter int         ADDR_W       = 10,
    parameter logic [3:0] SEL_VAL      = 4'hF,
    parameter int         WAIT         = 0,
    parameter bit         CLEAR_ON_RST = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [27:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT
);
    // state   | meaning
    // S_CLEAR | clear engine zeroing word[clr_cnt], bus stalled
    // S_IDLE  | accepting reads and writes, no stall
    // S_WAIT  | read accepted, wait counter running down, bus stalled
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT} state_t;

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [1:0]        wait_cnt, wait_cnt_nxt;
    logic              busy, busy_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic [31:0]       rdata_q;
    logic              do_load;
    logic [ADDR_W-1:0] do_addr;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              sel;
    logic              accept;
    logic [ADDR_W-1:0] bus_idx;
    logic              unused_bits;

    assign sel       = (IBUS_A[27:24] == SEL_VAL);
    assign accept    = IBUS_REQ & sel & ~busy;
    assign bus_idx   = IBUS_A[ADDR_W+1:2];
    assign IBUS_DO   = rdata_q;
    assign IBUS_BUSY = busy;
    assign IBUS_ACT  = sel;

    // CE_F exists only for port compatibility; upper address bits simply alias.
    assign unused_bits = ^{CE_F, IBUS_A};

    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        wait_cnt_nxt = wait_cnt;
        busy_nxt     = busy;
        rd_addr_nxt  = rd_addr;
        do_load      = 1'b0;
        do_addr      = bus_idx;
        mem_we       = 4'h0;
        mem_addr     = bus_idx;
        mem_wdata    = IBUS_DI;
        unique case (state)
            S_CLEAR: begin
                mem_we    = 4'hF;
                mem_addr  = clr_cnt;
                mem_wdata = 32'h0;
                busy_nxt  = 1'b1;
                if (&clr_cnt) begin
                    state_nxt   = S_IDLE;
                    busy_nxt    = 1'b0;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (IBUS_WE) begin
                        mem_we = IBUS_BA;
                    end else if (WAIT == 0) begin
                        do_load = 1'b1;
                    end else begin
                        wait_cnt_nxt = 2'(WAIT);
                        busy_nxt     = 1'b1;
                        rd_addr_nxt  = bus_idx;
                        state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Terminal count is 1 so BUSY spans exactly WAIT enabled periods.
                if (wait_cnt == 2'd1) begin
                    do_load      = 1'b1;
                    do_addr      = rd_addr;
                    busy_nxt     = 1'b0;
                    wait_cnt_nxt = 2'd0;
                    state_nxt    = S_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= CLEAR_ON_RST ? S_CLEAR : S_IDLE;
            busy     <= CLEAR_ON_RST;
            clr_cnt  <= '0;
            wait_cnt <= 2'd0;
            rd_addr  <= '0;
            rdata_q  <= 32'h0;
        end else if (CE_R) begin
            state    <= state_nxt;
            busy     <= busy_nxt;
            clr_cnt  <= clr_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            rd_addr  <= rd_addr_nxt;
            if (do_load) begin
                rdata_q <= mem[do_addr];
            end
        end
    end

    // Storage kept free of reset so it maps onto a plain RAM macro.
    always_ff @(posedge CLK) begin
        if (!RST && CE_R) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sh_ibus_ram.sv
// Bench for sh_ibus_ram: two instances (small window with wait states, full window
// without) checked against an array-based memory model and latency rules.
module tb_sh_ibus_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, ce_r, ce_f;
    logic [27:0] bus_a;
    logic [31:0] bus_di;
    logic [3:0]  bus_ba;
    logic        bus_we, req_a, req_b;
    logic [31:0] do_a, do_b;
    logic        busy_a, busy_b, act_a, act_b;

    sh_ibus_ram #(.ADDR_W(4), .SEL_VAL(4'hF), .WAIT(2), .CLEAR_ON_RST(1'b1)) u_ram_a (
        .CLK(clk), .RST(rst_a), .CE_R(ce_r), .CE_F(ce_f),
        .IBUS_A(bus_a), .IBUS_DI(bus_di), .IBUS_DO(do_a), .IBUS_BA(bus_ba),
        .IBUS_WE(bus_we), .IBUS_REQ(req_a), .IBUS_BUSY(busy_a), .IBUS_ACT(act_a)
    );

    sh_ibus_ram #(.ADDR_W(10), .SEL_VAL(4'hF), .WAIT(0), .CLEAR_ON_RST(1'b1)) u_ram_b (
        .CLK(clk), .RST(rst_b), .CE_R(ce_r), .CE_F(ce_f),
        .IBUS_A(bus_a), .IBUS_DI(bus_di), .IBUS_DO(do_b), .IBUS_BA(bus_ba),
        .IBUS_WE(bus_we), .IBUS_REQ(req_b), .IBUS_BUSY(busy_b), .IBUS_ACT(act_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_a [16];
    logic [31:0] ref_b [1024];
    logic [31:0] ref_do [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_do(input int w);
        return (w == 0) ? do_a : do_b;
    endfunction

    function automatic logic [31:0] dut_busy(input int w);
        return (w == 0) ? 32'(busy_a) : 32'(busy_b);
    endfunction

    function automatic logic [31:0] dut_act(input int w);
        return (w == 0) ? 32'(act_a) : 32'(act_b);
    endfunction

    function automatic int depth_of(input int w);
        return (w == 0) ? 16 : 1024;
    endfunction

    function automatic logic [31:0] ref_rd(input int w, input int idx);
        return (w == 0) ? ref_a[idx] : ref_b[idx];
    endfunction

    task automatic ref_wr(input int w, input int idx, input logic [31:0] d, input logic [3:0] ba);
        logic [31:0] nw;
        nw = ref_rd(w, idx);
        for (int i = 0; i < 4; i++) if (ba[i]) nw[8*i +: 8] = d[8*i +: 8];
        if (w == 0) ref_a[idx] = nw; else ref_b[idx] = nw;
    endtask

    task automatic ref_zero(input int w);
        for (int i = 0; i < depth_of(w); i++) ref_wr(w, i, 32'h0, 4'hF);
    endtask

    task automatic tick(input logic en);
        ce_r = en;
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; gap_pct percent of edges have CE_R low.
    task automatic access(input int w, input logic we, input logic [27:0] a,
                          input logic [31:0] di, input logic [3:0] ba, input int gap_pct);
        int          idx, nwait, lat, guard;
        logic        sel, en, done;
        logic [31:0] exp_do, pd, pb;
        sel   = (a[27:24] == 4'hF);
        idx   = int'((a >> 2) & 28'(depth_of(w) - 1));
        nwait = (sel && !we && w == 0) ? 2 : 0;
        bus_a = a; bus_di = di; bus_ba = ba; bus_we = we;
        if (w == 0) req_a = 1'b1; else req_b = 1'b1;
        #1;
        check_val("act", dut_act(w), 32'(sel));
        exp_do = ref_do[w];
        if (sel && we) ref_wr(w, idx, di, ba);
        if (sel && !we) exp_do = ref_rd(w, idx);
        lat = 0; guard = 0; done = 1'b0;
        while (!done && guard < 200) begin
            en = ($urandom_range(99) >= gap_pct);
            pd = dut_do(w);
            pb = dut_busy(w);
            tick(en);
            guard++;
            if (!en) begin
                check_val("frz_do", dut_do(w), pd);
                check_val("frz_busy", dut_busy(w), pb);
            end else begin
                lat++;
                if (lat <= nwait) begin
                    check_val("wait_busy", dut_busy(w), 32'h1);
                    check_val("wait_do", dut_do(w), ref_do[w]);
                end else begin
                    check_val("done_busy", dut_busy(w), 32'h0);
                    check_val(we ? "wr_do" : "rd_do", dut_do(w), exp_do);
                    done = 1'b1;
                end
            end
        end
        if (!done) check_val("acc_timeout", 32'h0, 32'h1);
        ref_do[w] = exp_do;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic do_reset(input int w);
        if (w == 0) rst_a = 1'b1; else rst_b = 1'b1;
        tick(1'b1);
        rst_a = 1'b0; rst_b = 1'b0;
        ref_do[w] = 32'h0;
        check_val("rst_busy", dut_busy(w), 32'h1);
        check_val("rst_do", dut_do(w), 32'h0);
    endtask

    task automatic run_clear(input int w, input int gap_pct, input string tag);
        int          n, guard;
        logic        en;
        logic [31:0] pb;
        n = 0; guard = 0;
        while (dut_busy(w) != 0 && guard < 5000) begin
            en = ($urandom_range(99) >= gap_pct);
            pb = dut_busy(w);
            tick(en);
            guard++;
            if (en) n++;
            else check_val({tag, "_frz"}, dut_busy(w), pb);
        end
        check_val({tag, "_len"}, 32'(n), 32'(depth_of(w)));
        check_val({tag, "_do"}, dut_do(w), 32'h0);
        ref_zero(w);
    endtask

    initial begin
        logic [27:0] ra;
        rst_a = 1'b1; rst_b = 1'b1; ce_r = 1'b1; ce_f = 1'b0;
        bus_a = 28'h0; bus_di = 32'h0; bus_ba = 4'h0; bus_we = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        ref_do[0] = 32'h0; ref_do[1] = 32'h0;
        tick(1'b1);
        tick(1'b1);
        rst_a = 1'b0; rst_b = 1'b0;
        check_val("init_busy_a", 32'(busy_a), 32'h1);
        check_val("init_busy_b", 32'(busy_b), 32'h1);
        check_val("init_do_a", do_a, 32'h0);
        run_clear(1, 0, "clr_b");
        check_val("init_idle_a", 32'(busy_a), 32'h0);
        ref_zero(0);

        // Preload, then reset must zero every word.
        for (int i = 0; i < 16; i++) access(0, 1'b1, 28'hF000000 + 28'(4*i), 32'hA5A5A5A5, 4'hF, 0);
        access(0, 1'b0, 28'hF00000C, 32'h0, 4'h0, 0);
        check_val("preload", do_a, 32'hA5A5A5A5);
        do_reset(0);
        run_clear(0, 0, "clr_a");
        for (int i = 0; i < 16; i++) access(0, 1'b0, 28'hF000000 + 28'(4*i), 32'h0, 4'h0, 0);

        // Byte lanes
        access(0, 1'b1, 28'hF000010, 32'h11223344, 4'hF, 0);
        access(0, 1'b1, 28'hF000010, 32'hAABBCCDD, 4'h5, 0);
        access(0, 1'b1, 28'hF000010, 32'hFFFFFFFF, 4'h0, 0);
        access(0, 1'b0, 28'hF000010, 32'h0, 4'h0, 0);
        check_val("lanes", do_a, 32'h11BB33DD);

        // Wait states, then a write immediately after
        access(0, 1'b1, 28'hF000020, 32'hDEADBEEF, 4'hF, 0);
        access(0, 1'b0, 28'hF000020, 32'h0, 4'h0, 0);
        check_val("wait_data", do_a, 32'hDEADBEEF);
        access(0, 1'b1, 28'hF000024, 32'h12345678, 4'hF, 0);

        // Read-after-write with CE_R gaps
        access(0, 1'b1, 28'hF000030, 32'hCAFEF00D, 4'hF, 0);
        access(0, 1'b0, 28'hF000030, 32'h0, 4'h0, 40);
        check_val("raw", do_a, 32'hCAFEF00D);
        access(1, 1'b1, 28'hF000040, 32'hCAFEF00D, 4'hF, 0);
        access(1, 1'b0, 28'hF000040, 32'h0, 4'h0, 40);
        check_val("raw_b", do_b, 32'hCAFEF00D);

        // Window alias and deselected write
        access(1, 1'b1, 28'hF000FFC, 32'h0BADC0DE, 4'hF, 0);
        access(1, 1'b0, 28'hF001FFC, 32'h0, 4'h0, 0);
        check_val("alias", do_b, 32'h0BADC0DE);
        access(1, 1'b1, 28'hE000FFC, 32'h11111111, 4'hF, 0);
        access(1, 1'b0, 28'hF000FFC, 32'h0, 4'h0, 0);
        check_val("desel", do_b, 32'h0BADC0DE);

        // Random traffic on both instances
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 200; n++) begin
                ra = {(($urandom_range(9) == 0) ? 4'($urandom_range(14)) : 4'hF), 24'($urandom)};
                access(w, 1'($urandom_range(1)), ra, $urandom, 4'($urandom_range(15)), 20);
            end
        end

        // Reset in the middle of a clear restarts the full sequence
        do_reset(0);
        for (int i = 0; i < 7; i++) tick(1'b1);
        check_val("midclr_busy", 32'(busy_a), 32'h1);
        do_reset(0);
        run_clear(0, 25, "clr_restart");

        // Reset during wait states discards the read
        access(0, 1'b1, 28'hF000020, 32'hDEADBEEF, 4'hF, 0);
        access(0, 1'b0, 28'hF000020, 32'h0, 4'h0, 0);
        bus_a = 28'hF000024; bus_we = 1'b0; req_a = 1'b1;
        tick(1'b1);
        check_val("midwait_busy", 32'(busy_a), 32'h1);
        tick(1'b1);
        req_a = 1'b0;
        do_reset(0);
        run_clear(0, 0, "clr_wait");
        access(0, 1'b0, 28'hF000020, 32'h0, 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
